// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Brief    : Requester-side and memory-side bundle of the memory port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*64-1:0] req_addr;
    logic [NREQ*64-1:0] req_wdata;
    logic [NREQ-1:0]    resp_valid;
    logic [63:0]        resp_data;
    logic               mem_ren;
    logic [63:0]        mem_raddr;
    logic               mem_rready;
    logic [63:0]        mem_rdata;
    logic               mem_wen;
    logic [63:0]        mem_waddr;
    logic [63:0]        mem_wdata;

    // Arbiter side
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rready, mem_rdata,
        output req_ready, resp_valid, resp_data, mem_ren, mem_raddr,
               mem_wen, mem_waddr, mem_wdata
    );

    // Requesters plus memory model side
    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rready, mem_rdata,
        input  req_ready, resp_valid, resp_data, mem_ren, mem_raddr,
               mem_wen, mem_waddr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Serialises NREQ requesters onto one memory port, one read in flight.
//             Define MEM_ARB_RR_EN for round-robin arbitration (fixed otherwise).
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int c_IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_IDX_W-1:0]  r_owner;
    logic                r_mem_ren;
    logic [63:0]         r_mem_raddr;
    logic                r_mem_wen;
    logic [63:0]         r_mem_waddr;
    logic [63:0]         r_mem_wdata;
    logic [NREQ-1:0]     r_resp_valid;
    logic [63:0]         r_resp_data;

    logic                w_any;
    logic                w_accept;
    logic [c_IDX_W-1:0]  w_grant_idx;
    logic [NREQ-1:0]     w_grant_oh;
    logic                w_sel_we;
    logic [63:0]         w_sel_addr;
    logic [63:0]         w_sel_wdata;

    assign w_any    = |bus.req_valid;
    assign w_accept = (r_state == ST_IDLE) && w_any && !rst;

`ifdef MEM_ARB_RR_EN
    logic [c_IDX_W-1:0]  r_ptr;

    // Winner is the valid requester with the smallest forward distance from r_ptr.
    always_comb begin
        int w_best_dist;
        int w_dist;
        w_grant_idx = '0;
        w_best_dist = NREQ;
        w_dist      = 0;
        for (int j = 0; j < NREQ; j++) begin
            w_dist = (j >= int'(r_ptr)) ? (j - int'(r_ptr)) : (j + NREQ - int'(r_ptr));
            if (bus.req_valid[j] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_grant_idx = c_IDX_W'(j);
            end
        end
    end
`else
    always_comb begin
        w_grant_idx = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (bus.req_valid[j]) begin
                w_grant_idx = c_IDX_W'(j);
            end
        end
    end
`endif

    always_comb begin
        w_grant_oh  = '0;
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_grant_idx == c_IDX_W'(j)) begin
                w_grant_oh[j] = w_accept;
                w_sel_we      = bus.req_we[j];
                w_sel_addr    = bus.req_addr[64*j +: 64];
                w_sel_wdata   = bus.req_wdata[64*j +: 64];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_mem_ren    <= 1'b0;
            r_mem_raddr  <= '0;
            r_mem_wen    <= 1'b0;
            r_mem_waddr  <= '0;
            r_mem_wdata  <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
`ifdef MEM_ARB_RR_EN
            r_ptr        <= '0;
`endif
        end else begin
            r_mem_wen    <= 1'b0;
            r_resp_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
`ifdef MEM_ARB_RR_EN
                        r_ptr <= (w_grant_idx == c_IDX_W'(NREQ - 1)) ? '0
                                                                     : w_grant_idx + c_IDX_W'(1);
`endif
                        if (w_sel_we) begin
                            r_mem_wen   <= 1'b1;
                            r_mem_waddr <= w_sel_addr;
                            r_mem_wdata <= w_sel_wdata;
                        end else begin
                            r_mem_ren   <= 1'b1;
                            r_mem_raddr <= w_sel_addr;
                            r_owner     <= w_grant_idx;
                            r_state     <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (bus.mem_rready) begin
                        r_mem_ren   <= 1'b0;
                        r_resp_data <= bus.mem_rdata;
                        for (int j = 0; j < NREQ; j++) begin
                            r_resp_valid[j] <= (r_owner == c_IDX_W'(j));
                        end
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = w_grant_oh;
    assign bus.mem_ren    = r_mem_ren;
    assign bus.mem_raddr  = r_mem_raddr;
    assign bus.mem_wen    = r_mem_wen;
    assign bus.mem_waddr  = r_mem_waddr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Brief    : Vector table, directed corner sequences and random traffic
//             against a transaction-level model of the memory port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int          NREQ = 2;
    localparam logic [63:0] Z    = 64'h0;
    localparam logic [63:0] ONES = 64'hffff_ffff_ffff_ffff;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_port_arbiter_if #(.NREQ(NREQ)) bus ();
    mem_port_arbiter #(.NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [63:0] a0, a1, d0, d1;
        logic        rready;
        logic [63:0] rdata;
        logic [1:0]  e_ready;
        logic        e_wen;
        logic [63:0] e_waddr, e_wdata;
        logic        e_ren;
        logic [63:0] e_raddr;
        logic [1:0]  e_rv;
        logic [63:0] e_rd;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [63:0] a0, input logic [63:0] a1,
                         input logic [63:0] d0, input logic [63:0] d1,
                         input logic rr, input logic [63:0] rd);
        bus.req_valid  = v;
        bus.req_we     = we;
        bus.req_addr   = {a1, a0};
        bus.req_wdata  = {d1, d0};
        bus.mem_rready = rr;
        bus.mem_rdata  = rd;
    endtask

    task automatic set_idle();
        drive(2'b00, 2'b00, Z, Z, Z, Z, 1'b0, Z);
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Reference arbitration: first valid requester in search order.
    function automatic int pick(input logic [1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
`ifdef MEM_ARB_RR_EN
            int idx = (ptr + k) % NREQ;
`else
            int idx = k + (ptr * 0);
`endif
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Random-test state
    logic [1:0]  p_valid, p_we;
    logic [63:0] p_addr[2];
    logic [63:0] p_wdata[2];
    bit          m_out;
    int          m_owner, m_ptr, g;
    logic        e_wen, e_ren;
    logic [63:0] e_waddr, e_wdata, e_raddr, e_rd;
    logic [1:0]  e_rv, exp_ready;

    initial begin
        // valid we a0 a1 d0 d1 rready rdata | ready wen waddr wdata ren raddr rv rd
        tbl[0]  = '{2'b10, 2'b10, Z, ONES, Z, 64'h41, 1'b0, Z, 2'b10, 1'b0, Z, Z, 1'b0, Z, 2'b00, Z};
        tbl[1]  = '{2'b00, 2'b00, Z, Z, Z, Z, 1'b0, Z, 2'b00, 1'b1, ONES, 64'h41, 1'b0, Z, 2'b00, Z};
        tbl[2]  = '{2'b00, 2'b00, Z, Z, Z, Z, 1'b0, Z, 2'b00, 1'b0, Z, Z, 1'b0, Z, 2'b00, Z};
        tbl[3]  = '{2'b01, 2'b00, 64'h1000, Z, Z, Z, 1'b0, Z, 2'b01, 1'b0, Z, Z, 1'b0, Z, 2'b00, Z};
        tbl[4]  = '{2'b00, 2'b00, Z, Z, Z, Z, 1'b0, Z, 2'b00, 1'b0, Z, Z, 1'b1, 64'h1000, 2'b00, Z};
        tbl[5]  = '{2'b10, 2'b00, Z, 64'h3000, Z, Z, 1'b0, Z, 2'b00, 1'b0, Z, Z, 1'b1, 64'h1000, 2'b00, Z};
        tbl[6]  = '{2'b10, 2'b00, Z, 64'h3000, Z, Z, 1'b1, 64'hDEADBEEF, 2'b00, 1'b0, Z, Z, 1'b1, 64'h1000, 2'b00, Z};
        tbl[7]  = '{2'b10, 2'b00, Z, 64'h3000, Z, Z, 1'b0, Z, 2'b10, 1'b0, Z, Z, 1'b0, Z, 2'b01, 64'hDEADBEEF};
        tbl[8]  = '{2'b00, 2'b00, Z, Z, Z, Z, 1'b0, Z, 2'b00, 1'b0, Z, Z, 1'b1, 64'h3000, 2'b00, Z};
        tbl[9]  = '{2'b00, 2'b00, Z, Z, Z, Z, 1'b1, 64'h12345678, 2'b00, 1'b0, Z, Z, 1'b1, 64'h3000, 2'b00, Z};
        tbl[10] = '{2'b00, 2'b00, Z, Z, Z, Z, 1'b0, Z, 2'b00, 1'b0, Z, Z, 1'b0, Z, 2'b10, 64'h12345678};
        tbl[11] = '{2'b00, 2'b00, Z, Z, Z, Z, 1'b1, 64'h0BAD, 2'b00, 1'b0, Z, Z, 1'b0, Z, 2'b00, Z};
        tbl[12] = '{2'b01, 2'b01, 64'h55, Z, 64'h66, Z, 1'b0, Z, 2'b01, 1'b0, Z, Z, 1'b0, Z, 2'b00, Z};
        tbl[13] = '{2'b01, 2'b00, 64'h77, Z, Z, Z, 1'b0, Z, 2'b01, 1'b1, 64'h55, 64'h66, 1'b0, Z, 2'b00, Z};
        tbl[14] = '{2'b00, 2'b00, Z, Z, Z, Z, 1'b1, 64'hAA, 2'b00, 1'b0, Z, Z, 1'b1, 64'h77, 2'b00, Z};
        tbl[15] = '{2'b00, 2'b00, Z, Z, Z, Z, 1'b0, Z, 2'b00, 1'b0, Z, Z, 1'b0, Z, 2'b01, 64'hAA};
        tbl[16] = '{2'b00, 2'b00, Z, Z, Z, Z, 1'b0, Z, 2'b00, 1'b0, Z, Z, 1'b0, Z, 2'b00, Z};

        do_reset();
        #1;
        chk("rst_ren",   bus.mem_ren,    Z);
        chk("rst_wen",   bus.mem_wen,    Z);
        chk("rst_raddr", bus.mem_raddr,  Z);
        chk("rst_waddr", bus.mem_waddr,  Z);
        chk("rst_wdata", bus.mem_wdata,  Z);
        chk("rst_rv",    bus.resp_valid, Z);
        chk("rst_rdata", bus.resp_data,  Z);
        chk("rst_ready", bus.req_ready,  Z);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].valid, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1,
                  tbl[i].rready, tbl[i].rdata);
            #1;
            chk($sformatf("tbl%0d_ready", i), bus.req_ready, tbl[i].e_ready);
            chk($sformatf("tbl%0d_wen", i),   bus.mem_wen,   tbl[i].e_wen);
            if (tbl[i].e_wen) begin
                chk($sformatf("tbl%0d_waddr", i), bus.mem_waddr, tbl[i].e_waddr);
                chk($sformatf("tbl%0d_wdata", i), bus.mem_wdata, tbl[i].e_wdata);
            end
            chk($sformatf("tbl%0d_ren", i), bus.mem_ren, tbl[i].e_ren);
            if (tbl[i].e_ren) chk($sformatf("tbl%0d_raddr", i), bus.mem_raddr, tbl[i].e_raddr);
            chk($sformatf("tbl%0d_rv", i), bus.resp_valid, tbl[i].e_rv);
            if (tbl[i].e_rv != 2'b00) chk($sformatf("tbl%0d_rdata", i), bus.resp_data, tbl[i].e_rd);
            cyc();
        end

        // Contention: both ports write continuously for four cycles.
        do_reset();
        drive(2'b11, 2'b11, 64'hA0, 64'hA1, 64'hD0, 64'hD1, 1'b0, Z);
        g = -1;
        for (int k = 0; k < 4; k++) begin
            int w;
`ifdef MEM_ARB_RR_EN
            w = k % 2;
`else
            w = 0;
`endif
            #1;
            chk($sformatf("cont%0d_ready", k), bus.req_ready, (w == 0) ? 2'b01 : 2'b10);
            if (g >= 0) begin
                chk($sformatf("cont%0d_wen", k),   bus.mem_wen,   1'b1);
                chk($sformatf("cont%0d_waddr", k), bus.mem_waddr, (g == 0) ? 64'hA0 : 64'hA1);
                chk($sformatf("cont%0d_wdata", k), bus.mem_wdata, (g == 0) ? 64'hD0 : 64'hD1);
            end
            g = w;
            cyc();
        end
        set_idle();
        #1;
        chk("cont_last_wen",   bus.mem_wen,   1'b1);
        chk("cont_last_waddr", bus.mem_waddr, (g == 0) ? 64'hA0 : 64'hA1);

        // Write stream: 26 console writes from port 1 with no bubbles.
        do_reset();
        for (int k = 0; k < 26; k++) begin
            drive(2'b10, 2'b10, Z, ONES, Z, 64'h41 + 64'(k), 1'b0, Z);
            #1;
            chk($sformatf("strm%0d_ready", k), bus.req_ready, 2'b10);
            if (k > 0) begin
                chk($sformatf("strm%0d_wen", k),   bus.mem_wen,   1'b1);
                chk($sformatf("strm%0d_wdata", k), bus.mem_wdata, 64'h41 + 64'(k - 1));
            end
            cyc();
        end
        set_idle();
        #1;
        chk("strm_last_wen",   bus.mem_wen,   1'b1);
        chk("strm_last_waddr", bus.mem_waddr, ONES);
        chk("strm_last_wdata", bus.mem_wdata, 64'h5A);
        cyc();
        chk("strm_end_wen", bus.mem_wen, 1'b0);

        // Reset while a read is outstanding, then a stale mem_rready.
        do_reset();
        drive(2'b01, 2'b00, 64'h1000, Z, Z, Z, 1'b0, Z);
        cyc();
        set_idle();
        #1;
        chk("rstrd_ren_up", bus.mem_ren, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rstrd_ren_dn", bus.mem_ren, 1'b0);
        chk("rstrd_rv0", bus.resp_valid, 2'b00);
        cyc();
        cyc();
        drive(2'b00, 2'b00, Z, Z, Z, Z, 1'b1, 64'h99);
        cyc();
        set_idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("rstrd_rv%0d", k + 1), bus.resp_valid, 2'b00);
            chk($sformatf("rstrd_ren%0d", k + 1), bus.mem_ren, 1'b0);
            cyc();
        end
        drive(2'b01, 2'b00, 64'h2000, Z, Z, Z, 1'b0, Z);
        #1;
        chk("rstrd_next_ready", bus.req_ready, 2'b01);
        cyc();
        drive(2'b00, 2'b00, Z, Z, Z, Z, 1'b1, 64'h4242);
        #1;
        chk("rstrd_next_ren",   bus.mem_ren,   1'b1);
        chk("rstrd_next_raddr", bus.mem_raddr, 64'h2000);
        cyc();
        set_idle();
        #1;
        chk("rstrd_next_rv",    bus.resp_valid, 2'b01);
        chk("rstrd_next_rdata", bus.resp_data,  64'h4242);

        // Random traffic against the transaction-level model.
        do_reset();
        p_valid = '0; p_we = '0;
        p_addr[0] = Z; p_addr[1] = Z; p_wdata[0] = Z; p_wdata[1] = Z;
        m_out = 1'b0; m_owner = 0; m_ptr = 0;
        e_wen = 1'b0; e_ren = 1'b0; e_rv = '0;
        e_waddr = Z; e_wdata = Z; e_raddr = Z; e_rd = Z;
        for (int c = 0; c < 400; c++) begin
            logic        rr;
            logic [63:0] rd;
            for (int i = 0; i < NREQ; i++) begin
                if (!p_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    p_valid[i] = 1'b1;
                    p_we[i]    = 1'($urandom_range(0, 1));
                    p_addr[i]  = {$urandom, $urandom};
                    p_wdata[i] = {$urandom, $urandom};
                end
            end
            rr = ($urandom_range(0, 2) == 0);
            rd = {$urandom, $urandom};
            drive(p_valid, p_we, p_addr[0], p_addr[1], p_wdata[0], p_wdata[1], rr, rd);
            #1;
            g = m_out ? -1 : pick(p_valid, m_ptr);
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("rnd_ready", bus.req_ready, exp_ready);
            chk("rnd_wen", bus.mem_wen, e_wen);
            if (e_wen) begin
                chk("rnd_waddr", bus.mem_waddr, e_waddr);
                chk("rnd_wdata", bus.mem_wdata, e_wdata);
            end
            chk("rnd_ren", bus.mem_ren, e_ren);
            if (e_ren) chk("rnd_raddr", bus.mem_raddr, e_raddr);
            chk("rnd_rv", bus.resp_valid, e_rv);
            if (e_rv != 2'b00) chk("rnd_rdata", bus.resp_data, e_rd);

            e_wen = 1'b0;
            e_rv  = '0;
            if (m_out && rr) begin
                e_rv[m_owner] = 1'b1;
                e_rd  = rd;
                m_out = 1'b0;
                e_ren = 1'b0;
            end else if (g >= 0) begin
                m_ptr = (g + 1) % NREQ;
                if (p_we[g]) begin
                    e_wen   = 1'b1;
                    e_waddr = p_addr[g];
                    e_wdata = p_wdata[g];
                end else begin
                    m_out   = 1'b1;
                    m_owner = g;
                    e_ren   = 1'b1;
                    e_raddr = p_addr[g];
                end
                p_valid[g] = 1'b0;
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the CPU's single external memory port. It accepts read and write requests from NREQ internal requesters, for example port 0 = instruction fetch and port 1 = load/store unit. It serialises those requests onto the mem_ren/mem_raddr/mem_rready/mem_rdata and mem_wen/mem_waddr/mem_wdata interface, and routes read data back to the requester that issued the read. Writes are posted and complete immediately; console output (writes to 64'hffffffffffffffff) is an ordinary write to this block. At most one read is outstanding.

## Interface
- NREQ, default 2: number of requesters, range 2..8.
- clk  in  1: clock; all state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- req_valid  in  NREQ: request present, one bit per requester.
- req_ready  out  NREQ: request accepted this cycle; combinational; one-hot or zero.
- req_we  in  NREQ: 1 = write, 0 = read.
- req_addr  in  NREQ*64: request address; requester i uses bits [64*i +: 64].
- req_wdata  in  NREQ*64: write data; requester i uses bits [64*i +: 64].
- resp_valid  out  NREQ: one-cycle pulse, read data valid for that requester.
- resp_data  out  64: read data, shared by all requesters; valid only while some resp_valid bit is high.
- mem_ren  out  1: memory read enable; held high until the read completes.
- mem_raddr  out  64: read address; stable while mem_ren is high.
- mem_rready  in  1: read data valid, one-cycle pulse.
- mem_rdata  in  64: read data; sampled when mem_rready is high.
- mem_wen  out  1: memory write enable, one-cycle pulse per write.
- mem_waddr  out  64: write address; valid when mem_wen is high.
- mem_wdata  out  64: write data; valid when mem_wen is high.

## Operation
- FSM states are IDLE and RD_WAIT. After reset the block is in IDLE.
- **IDLE:**
  - If any req_valid bit is set, the arbiter picks grant index g and drives req_ready[g]=1 in the same cycle. No other req_ready bit is high.
  - Accepted write: on the next cycle mem_wen=1, mem_waddr=req_addr[g] and mem_wdata=req_wdata[g]. The FSM stays in IDLE, so back-to-back writes sustain one per cycle.
  - Accepted read: on the next cycle mem_ren=1 and mem_raddr=req_addr[g]. The block latches g as the owner and moves to RD_WAIT.
- **RD_WAIT:**
  - All req_ready bits are 0.
  - mem_ren and mem_raddr are held.
  - When mem_rready=1, the block captures mem_rdata. On the next cycle it drives resp_valid[owner]=1 with resp_data equal to the captured data, drives mem_ren=0, and returns to IDLE. It may accept a new request in that same cycle.
- **Default arbitration (fixed priority):** the lowest-index valid requester wins.
- All memory-side outputs and resp_* are registered.
- mem_rready while in IDLE is ignored; no response is produced.
- Requesters must hold req_valid, req_we, req_addr and req_wdata stable until accepted. The block must not depend on this for correctness of granted requests.

## Timing
- Reset values: mem_ren=0, mem_wen=0, mem_raddr=0, mem_waddr=0, mem_wdata=0, resp_valid=0, resp_data=0, FSM=IDLE. The round-robin pointer resets to 0.
- Write latency: accepted at cycle T; mem_wen is high at T+1 only.
- Read latency:
  - Accepted at cycle T; mem_ren rises at T+1.
  - If mem_rready arrives at cycle R (R≥T+1), then resp_valid is high at R+1 and mem_ren is low at R+1.
  - The earliest next read has mem_ren high at R+2.
- mem_rready may arrive in the same cycle mem_ren first rises (T+1). That cycle counts as R.
- Reset in RD_WAIT: the outstanding read is abandoned. mem_ren=0 and no resp_valid is issued. Any later mem_rready is ignored.
- rst has priority over every other event in the same cycle.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A pointer p (width $clog2(NREQ)) gives the first requester searched: p, p+1, …, modulo NREQ.
  - After each grant g, p becomes (g+1) mod NREQ.
  - The pointer only updates on an accepted request.
- MEM_ARB_RR_EN undefined: fixed priority with index 0 highest. No pointer state exists.

## Test plan
- Single write: req_valid=2'b10, req_we[1]=1, addr=64'hffffffffffffffff, wdata=64'h41 → req_ready=2'b10 the same cycle; the next cycle mem_wen=1, mem_waddr=64'hffffffffffffffff, mem_wdata=64'h41; one pulse only.
- Read round trip:
  - Stimulus: port 0 reads addr 64'h1000; memory returns 64'hDEADBEEF two cycles after mem_ren rises.
  - Required: mem_raddr=64'h1000 held for the whole read; resp_valid=2'b01 with resp_data=64'hDEADBEEF one cycle after mem_rready; no req_ready during RD_WAIT.
- Contention, fixed priority: both ports issue continuous writes for 4 cycles → port 0 granted on all 4 cycles. With MEM_ARB_RR_EN defined → grants alternate 0,1,0,1.
- Write stream: port 1 issues 26 consecutive writes of 64'h41..64'h5A to 64'hffffffffffffffff → 26 consecutive mem_wen cycles in order, with no bubbles.
- Reset mid-read:
  - Stimulus: rst asserted while in RD_WAIT; mem_rready pulsed 2 cycles after reset is released.
  - Required: mem_ren=0 the cycle after rst; resp_valid stays 0.
- Stray mem_rready in IDLE → no resp_valid and no state change; a following read behaves normally.
